// File: rtl/led_session_arbiter_if.sv
// Bundle of requester-side and LED-side signals for led_session_arbiter.
//   master : requester/test side, drives req and limit, observes everything else
//   slave  : the arbiter itself
// Signals:
//   req       level request per requester
//   limit     per-requester final count, slice i = limit[i*LED_W +: LED_W]
//   grant     one-hot (or zero) current owner
//   owner     index of current/last owner
//   busy      session in progress (COUNT or DONE)
//   led       counter value, zero outside COUNT
//   done      one-cycle completion pulse to the owner
//   fsm_state debug view of the arbiter FSM (0 IDLE, 1 COUNT, 2 DONE)
interface led_session_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int LED_W   = 4
);
  localparam int OWN_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*LED_W-1:0] limit;
  logic [NUM_REQ-1:0]       grant;
  logic [OWN_W-1:0]         owner;
  logic                     busy;
  logic [LED_W-1:0]         led;
  logic [NUM_REQ-1:0]       done;
  logic [1:0]               fsm_state;

  modport master (
    output req, limit,
    input  grant, owner, busy, led, done, fsm_state
  );

  modport slave (
    input  req, limit,
    output grant, owner, busy, led, done, fsm_state
  );
endinterface

// File: rtl/led_session_arbiter.sv
// Round-robin arbiter sharing one tick-paced LED counter among NUM_REQ
// requesters. The winner gets a session: led counts 0..limit at tick rate,
// then a one-tick DONE phase, then a one-cycle done pulse to the owner.
// Handshake: req[i] is a level request; the arbiter samples it on every
// clk edge. A grant appears after the edge that sampled req high, and the
// session continues only while the owner keeps req high; a low owner req on
// any edge of the session aborts it (no done pulse).
// Ports:
//   clk   system clock
//   rst   asynchronous, active-high reset
//   bus   led_session_arbiter_if slave modport (req, limit in; grant, owner,
//         busy, led, done, fsm_state out)
module led_session_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int LED_W    = 4,
  parameter int TICK_DIV = 3000000
) (
  input  logic                  clk,
  input  logic                  rst,
  led_session_arbiter_if.slave  bus
);
  localparam int OWN_W  = $clog2(NUM_REQ);
  localparam int TICK_W = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [OWN_W-1:0]     owner_q, owner_d;
  logic [LED_W-1:0]     led_q, led_d;
  logic [LED_W-1:0]     lim_q, lim_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [OWN_W-1:0]     rr_q, rr_d;
  logic [TICK_W-1:0]    tcnt_q, tcnt_d;

  logic                 tick;
  logic                 owner_req;
  logic                 win_valid;
  logic [OWN_W-1:0]     win;
  logic [OWN_W-1:0]     next_rr;

  function automatic logic [OWN_W-1:0] rr_idx(input logic [OWN_W-1:0] base, input int off);
    return OWN_W'((int'(base) + off) % NUM_REQ);
  endfunction

  assign tick      = (tcnt_q == TICK_W'(TICK_DIV - 1));
  assign owner_req = bus.req[owner_q];
  assign next_rr   = (owner_q == OWN_W'(NUM_REQ - 1)) ? '0 : owner_q + OWN_W'(1);

  // First set request at or after the round-robin pointer, wrapping.
  always_comb begin
    win       = '0;
    win_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_valid && bus.req[rr_idx(rr_q, i)]) begin
        win       = rr_idx(rr_q, i);
        win_valid = 1'b1;
      end
    end
  end

  // State register and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      led_q   <= '0;
      lim_q   <= '0;
      done_q  <= '0;
      rr_q    <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      led_q   <= led_d;
      lim_q   <= lim_d;
      done_q  <= done_d;
      rr_q    <= rr_d;
      tcnt_q  <= tcnt_d;
    end
  end

  // Next-state logic. Abort (owner req low) takes priority over tick.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (win_valid) state_d = S_COUNT;
      S_COUNT: begin
        if (!owner_req)                 state_d = S_IDLE;
        else if (tick && led_q == lim_q) state_d = S_DONE;
      end
      S_DONE:  if (!owner_req || tick) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath / output next values.
  always_comb begin
    grant_d = grant_q;
    owner_d = owner_q;
    led_d   = led_q;
    lim_d   = lim_q;
    done_d  = '0;
    rr_d    = rr_q;
    tcnt_d  = tcnt_q;
    case (state_q)
      S_IDLE: begin
        grant_d = '0;
        led_d   = '0;
        tcnt_d  = '0;
        if (win_valid) begin
          grant_d = NUM_REQ'(1) << win;
          owner_d = win;
          lim_d   = bus.limit[int'(win)*LED_W +: LED_W];
        end
      end
      S_COUNT: begin
        if (!owner_req) begin
          grant_d = '0;
          led_d   = '0;
          tcnt_d  = '0;
          rr_d    = next_rr;
        end else if (tick) begin
          // Tick counter wraps here, which also clears it on entry to DONE.
          tcnt_d = '0;
          led_d  = (led_q == lim_q) ? '0 : led_q + LED_W'(1);
        end else begin
          tcnt_d = tcnt_q + TICK_W'(1);
        end
      end
      S_DONE: begin
        if (!owner_req) begin
          grant_d = '0;
          led_d   = '0;
          tcnt_d  = '0;
          rr_d    = next_rr;
        end else if (tick) begin
          done_d  = grant_q;
          grant_d = '0;
          tcnt_d  = '0;
          rr_d    = next_rr;
        end else begin
          tcnt_d = tcnt_q + TICK_W'(1);
        end
      end
      default: begin
        grant_d = '0;
        led_d   = '0;
        tcnt_d  = '0;
      end
    endcase
  end

  assign bus.grant     = grant_q;
  assign bus.owner     = owner_q;
  assign bus.led       = led_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state_q == S_COUNT) || (state_q == S_DONE);
  assign bus.fsm_state = state_q;
endmodule

// File: tb/tb_led_session_arbiter.sv
module tb_led_session_arbiter;
  localparam int N = 4;
  localparam int W = 4;
  localparam int D = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  led_session_arbiter_if #(.NUM_REQ(N), .LED_W(W)) bus ();

  led_session_arbiter #(.NUM_REQ(N), .LED_W(W), .TICK_DIV(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- behavioural model ----------------
  // A session is described by its owner, latched limit and the number of
  // edges since the grant edge; all outputs follow from that arithmetic.
  bit          m_active;
  int          m_owner;
  int          m_lim;
  int          m_elapsed;
  int          m_rr;
  logic [N-1:0] m_done;
  logic [W-1:0] exp_q[$];

  task automatic model_reset();
    m_active  = 1'b0;
    m_owner   = 0;
    m_lim     = 0;
    m_elapsed = 0;
    m_rr      = 0;
    m_done    = '0;
    exp_q.delete();
  endtask

  task automatic model_edge(input logic [N-1:0] r, input logic [N*W-1:0] l);
    bit found;
    m_done = '0;
    if (m_active) begin
      if (!r[m_owner]) begin
        m_active = 1'b0;
        m_rr     = (m_owner + 1) % N;
      end else begin
        m_elapsed++;
        if (m_elapsed == (m_lim + 2) * D) begin
          m_active         = 1'b0;
          m_done[m_owner]  = 1'b1;
          m_rr             = (m_owner + 1) % N;
        end
      end
    end else if (r != '0) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (!found && r[(m_rr + k) % N]) begin
          m_owner = (m_rr + k) % N;
          found   = 1'b1;
        end
      end
      m_lim     = int'(l[m_owner*W +: W]);
      m_active  = 1'b1;
      m_elapsed = 0;
    end
  endtask

  function automatic logic [W-1:0] model_led();
    if (m_active && m_elapsed < (m_lim + 1) * D) return W'(m_elapsed / D);
    return '0;
  endfunction

  // ---------------- checking ----------------
  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_outputs();
    logic [W-1:0] e_led;
    e_led = exp_q.pop_front();
    check_eq("grant", 32'(bus.grant), m_active ? (32'd1 << m_owner) : 32'd0);
    check_eq("owner", 32'(bus.owner), 32'(m_owner));
    check_eq("busy",  32'(bus.busy),  32'(m_active));
    check_eq("led",   32'(bus.led),   32'(e_led));
    check_eq("done",  32'(bus.done),  32'(m_done));
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change on the falling edge; the model advances for the coming
  // rising edge; outputs are compared on the next falling edge.
  task automatic step(input logic [N-1:0] r, input logic [N*W-1:0] l);
    bus.req   = r;
    bus.limit = l;
    model_edge(r, l);
    exp_q.push_back(model_led());
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    bus.req = '0;
    rst     = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    exp_q.push_back('0);
    check_outputs();
  endtask

  function automatic logic [N*W-1:0] lims(input int a, input int b, input int c, input int d);
    return {W'(d), W'(c), W'(b), W'(a)};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int max_led;
    int g_own[$];
    int g_cyc[$];
    logic [N-1:0] prev_g;
    logic [N-1:0] r;
    logic [N*W-1:0] l;

    bus.req   = '0;
    bus.limit = '0;
    model_reset();

    // 1: single session, limit 3
    do_reset();
    step(4'b0001, lims(3, 0, 0, 0));
    check_eq("t1_grant", 32'(bus.grant), 32'h1);
    n = 0;
    while (bus.done == '0 && n < 100) begin
      step(4'b0001, lims(3, 0, 0, 0));
      n++;
      if (n == 5) check_eq("t1_led_at5", 32'(bus.led), 32'd1);
    end
    check_eq("t1_grant_to_done", 32'(n), 32'd20);
    check_eq("t1_done", 32'(bus.done), 32'h1);
    check_eq("t1_grant_off", 32'(bus.grant), 32'h0);
    step(4'b0000, lims(3, 0, 0, 0));

    // 2: everyone requesting, limits 0: round-robin order and session period
    do_reset();
    prev_g = '0;
    for (int k = 0; k < 60 && g_own.size() < 5; k++) begin
      step(4'b1111, lims(0, 0, 0, 0));
      if (bus.grant != '0 && prev_g == '0) begin
        g_own.push_back(int'(bus.owner));
        g_cyc.push_back(k);
      end
      prev_g = bus.grant;
    end
    check_eq("t2_grant_count", 32'(g_own.size()), 32'd5);
    for (int k = 0; k < g_own.size(); k++) begin
      check_eq("t2_order", 32'(g_own[k]), 32'(k % N));
      if (k > 0) check_eq("t2_period", 32'(g_cyc[k] - g_cyc[k-1]), 32'd9);
    end

    // 3: abort mid-count, pointer moves past the aborted owner
    do_reset();
    step(4'b0100, lims(0, 0, 5, 0));
    n = 0;
    while (bus.led != 4'd2 && n < 50) begin
      step(4'b0100, lims(0, 0, 5, 0));
      n++;
    end
    check_eq("t3_reach_led2", 32'(bus.led), 32'd2);
    step(4'b0000, lims(0, 0, 5, 0));
    check_eq("t3_abort_grant", 32'(bus.grant), 32'h0);
    check_eq("t3_abort_led", 32'(bus.led), 32'h0);
    check_eq("t3_abort_done", 32'(bus.done), 32'h0);
    step(4'b1010, lims(0, 0, 5, 0));
    check_eq("t3_next_grant", 32'(bus.grant), 32'h8);
    check_eq("t3_next_owner", 32'(bus.owner), 32'd3);

    // 4: limit 15 reaches the top without wrap; mid-session limit change ignored
    do_reset();
    step(4'b0001, lims(15, 0, 0, 0));
    max_led = 0;
    n = 0;
    while (bus.done == '0 && n < 200) begin
      l = (n >= 10) ? lims(0, 0, 0, 0) : lims(15, 0, 0, 0);
      step(4'b0001, l);
      if (int'(bus.led) > max_led) max_led = int'(bus.led);
      n++;
    end
    check_eq("t4_max_led", 32'(max_led), 32'd15);
    check_eq("t4_session_len", 32'(n), 32'd68);
    check_eq("t4_done", 32'(bus.done), 32'h1);

    // 5: asynchronous reset mid-count clears pointer
    do_reset();
    step(4'b0100, lims(0, 0, 0, 0));
    n = 0;
    while (bus.done == '0 && n < 50) begin
      step(4'b0100, lims(0, 0, 0, 0));
      n++;
    end
    step(4'b1000, lims(0, 0, 0, 5));
    n = 0;
    while (bus.led != 4'd2 && n < 50) begin
      step(4'b1000, lims(0, 0, 0, 5));
      n++;
    end
    check_eq("t5_reach_led2", 32'(bus.led), 32'd2);
    #2 rst = 1'b1;
    #1;
    check_eq("t5_rst_grant", 32'(bus.grant), 32'h0);
    check_eq("t5_rst_owner", 32'(bus.owner), 32'h0);
    check_eq("t5_rst_busy",  32'(bus.busy),  32'h0);
    check_eq("t5_rst_led",   32'(bus.led),   32'h0);
    check_eq("t5_rst_done",  32'(bus.done),  32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back('0);
    check_outputs();
    step(4'b1010, lims(0, 0, 0, 0));
    check_eq("t5_grant_after_rst", 32'(bus.grant), 32'h2);

    // 6: new request on the done edge waits one IDLE cycle
    do_reset();
    step(4'b0001, lims(0, 0, 0, 0));
    for (int k = 0; k < 7; k++) step(4'b0001, lims(0, 0, 0, 0));
    step(4'b0011, lims(0, 0, 0, 0));
    check_eq("t6_done", 32'(bus.done), 32'h1);
    check_eq("t6_no_grant", 32'(bus.grant), 32'h0);
    step(4'b0011, lims(0, 0, 0, 0));
    check_eq("t6_grant1", 32'(bus.grant), 32'h2);
    check_eq("t6_done_clear", 32'(bus.done), 32'h0);

    // random traffic against the model
    do_reset();
    r = '0;
    l = '0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 7) == 0) r[$urandom_range(0, N-1)] = ~r[$urandom_range(0, N-1)];
      if ($urandom_range(0, 5) == 0) r ^= N'(1) << $urandom_range(0, N-1);
      if ($urandom_range(0, 15) == 0) begin
        for (int j = 0; j < N; j++)
          l[j*W +: W] = ($urandom_range(0, 9) == 0) ? W'($urandom_range(0, 15))
                                                    : W'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 499) == 0) do_reset();
      step(r, l);
    end

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end
endmodule
